// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard unit.
//
// Purpose: forwarding selects for the execute stage, load-use and
// multi-cycle-unit interlocks, and taken-branch decode stalls.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   rsD, rdD          decode-stage source / destination registers
//   rsE, rdE          execute-stage operand registers
//   writeregE/M/W     destination register of the E, M, W stages
//   regwriteM/W       register-write enables of the M, W stages
//   memtoregE/liE/inE E-stage instruction produces a late result
//   pcsrcD            branch taken in decode
//   mcstartE, mcdstE  multi-cycle op issued in E and its destination
//   mcopD             decode-stage instruction uses the multi-cycle unit
//   forwardAE/BE      forward selects for rdE / rsE (10=M, 01=W, 00=regfile)
//   stallF, stallD    fetch / decode stall
//   flushE            execute-stage bubble
//   mcbusy, mcdone    multi-cycle unit busy / one-cycle completion pulse
//   perf_stalls       stall-cycle counter, saturating (HAZARD_PERF_EN only)
//
// Build option: define HAZARD_PERF_EN to add the perf_stalls port and counter.

module hazard_ctrl #(
    parameter int AW         = 3,
    parameter int BR_PENALTY = 1,
    parameter int MC_LAT     = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rsD,
    input  logic [AW-1:0] rdD,
    input  logic [AW-1:0] rsE,
    input  logic [AW-1:0] rdE,
    input  logic [AW-1:0] writeregE,
    input  logic [AW-1:0] writeregM,
    input  logic [AW-1:0] writeregW,
    input  logic          regwriteM,
    input  logic          regwriteW,
    input  logic          memtoregE,
    input  logic          liE,
    input  logic          inE,
    input  logic          pcsrcD,
    input  logic          mcstartE,
    input  logic [AW-1:0] mcdstE,
    input  logic          mcopD,
    output logic [1:0]    forwardAE,
    output logic [1:0]    forwardBE,
    output logic          stallF,
    output logic          stallD,
    output logic          flushE,
    output logic          mcbusy,
    output logic          mcdone
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]   perf_stalls
`endif
);

    logic [3:0]    mccnt;
    logic [AW-1:0] mcdst;
    logic [2:0]    brcnt;
    logic          lwstall;
    logic          mcstall;
    logic          brstall;

    // Forwarding: M stage has priority over W stage.
    always_comb begin
        forwardBE = 2'b00;
        if (regwriteM && (rsE == writeregM))
            forwardBE = 2'b10;
        else if (regwriteW && (rsE == writeregW))
            forwardBE = 2'b01;

        forwardAE = 2'b00;
        if (regwriteM && (rdE == writeregM))
            forwardAE = 2'b10;
        else if (regwriteW && (rdE == writeregW))
            forwardAE = 2'b01;
    end

    // Multi-cycle unit tracking; a start while busy is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            mccnt <= '0;
            mcdst <= '0;
        end else if (mcstartE && !mcbusy) begin
            mccnt <= 4'(MC_LAT);
            mcdst <= mcdstE;
        end else if (mcbusy) begin
            mccnt <= mccnt - 4'd1;
        end
    end

    // Branch penalty counter; a taken branch only reloads once it is idle.
    always_ff @(posedge clk) begin
        if (reset)
            brcnt <= '0;
        else if (pcsrcD && (brcnt == 3'd0))
            brcnt <= 3'(BR_PENALTY);
        else if (brcnt != 3'd0)
            brcnt <= brcnt - 3'd1;
    end

    always_comb begin
        mcbusy  = (mccnt != 4'd0);
        mcdone  = (mccnt == 4'd1);
        lwstall = ((rsD == writeregE) || (rdD == writeregE)) && (memtoregE || liE || inE);
        mcstall = mcbusy && ((rsD == mcdst) || (rdD == mcdst) || mcopD);
        brstall = pcsrcD || (brcnt != 3'd0);
        stallF  = lwstall || mcstall;
        stallD  = lwstall || mcstall || brstall;
        flushE  = lwstall || mcstall;
    end

`ifdef HAZARD_PERF_EN
    logic [15:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            perf_cnt <= '0;
        else if ((stallF || stallD) && (perf_cnt != '1))
            perf_cnt <= perf_cnt + 16'd1;
    end

    assign perf_stalls = perf_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rsD, rdD, rsE, rdE, writeregE, writeregM, writeregW, mcdstE;
    logic       regwriteM, regwriteW, memtoregE, liE, inE, pcsrcD, mcstartE, mcopD;
    logic [1:0] forwardAE, forwardBE;
    logic       stallF, stallD, flushE, mcbusy, mcdone;
`ifdef HAZARD_PERF_EN
    logic [15:0] perf_stalls;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.AW(3), .BR_PENALTY(2), .MC_LAT(4)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rdD(rdD), .rsE(rsE), .rdE(rdE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .liE(liE), .inE(inE), .pcsrcD(pcsrcD),
        .mcstartE(mcstartE), .mcdstE(mcdstE), .mcopD(mcopD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .mcbusy(mcbusy), .mcdone(mcdone)
`ifdef HAZARD_PERF_EN
        , .perf_stalls(perf_stalls)
`endif
    );

    typedef struct {
        logic [2:0] rsD, rdD, rsE, rdE, wE, wM, wW;
        logic       rwM, rwW, mem, li, in_, mcop;
        logic [1:0] fa, fb;
        logic       st;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rsD = 0; rdD = 0; rsE = 0; rdE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0; mcdstE = 0;
        regwriteM = 0; regwriteW = 0; memtoregE = 0; liE = 0; inE = 0;
        pcsrcD = 0; mcstartE = 0; mcopD = 0;
    endtask

    initial begin
        //          rsD rdD rsE rdE wE wM wW rwM rwW mem li in mcop  fa fb st
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 3, 0, 0, 3, 3, 1, 1, 0, 0, 0, 0, 0, 2, 0};
        vecs[2]  = '{0, 0, 3, 0, 0, 3, 3, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        vecs[3]  = '{0, 0, 1, 4, 0, 4, 1, 1, 1, 0, 0, 0, 0, 2, 1, 0};
        vecs[4]  = '{0, 0, 0, 6, 0, 6, 6, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        vecs[5]  = '{0, 5, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        vecs[6]  = '{0, 5, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[7]  = '{2, 7, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        vecs[8]  = '{1, 3, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[10] = '{7, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        vecs[11] = '{0, 0, 5, 5, 0, 5, 5, 1, 1, 0, 0, 0, 0, 2, 2, 0};

        // Reset state
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset_mcbusy", 16'(mcbusy), 16'd0);
        check("reset_mcdone", 16'(mcdone), 16'd0);
        check("reset_stallD", 16'(stallD), 16'd0);

        // Combinational table
        for (int i = 0; i < 12; i++) begin
            rsD = vecs[i].rsD; rdD = vecs[i].rdD; rsE = vecs[i].rsE; rdE = vecs[i].rdE;
            writeregE = vecs[i].wE; writeregM = vecs[i].wM; writeregW = vecs[i].wW;
            regwriteM = vecs[i].rwM; regwriteW = vecs[i].rwW;
            memtoregE = vecs[i].mem; liE = vecs[i].li; inE = vecs[i].in_; mcopD = vecs[i].mcop;
            #2;
            check($sformatf("v%0d_forwardAE", i), 16'(forwardAE), 16'(vecs[i].fa));
            check($sformatf("v%0d_forwardBE", i), 16'(forwardBE), 16'(vecs[i].fb));
            check($sformatf("v%0d_stallF", i), 16'(stallF), 16'(vecs[i].st));
            check($sformatf("v%0d_stallD", i), 16'(stallD), 16'(vecs[i].st));
            check($sformatf("v%0d_flushE", i), 16'(flushE), 16'(vecs[i].st));
        end
        idle_inputs();
        tick();

        // Multi-cycle op: 4 busy cycles, done in the 4th; a second start mid-op is ignored
        mcstartE = 1; mcdstE = 2; rsD = 2;
        #1;
        check("mc_pre_busy", 16'(mcbusy), 16'd0);
        tick();
        mcstartE = 0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check($sformatf("mc_c%0d_busy", c), 16'(mcbusy), 16'd1);
            check($sformatf("mc_c%0d_stallD", c), 16'(stallD), 16'd1);
            check($sformatf("mc_c%0d_flushE", c), 16'(flushE), 16'd1);
            check($sformatf("mc_c%0d_done", c), 16'(mcdone), 16'(c == 4));
            mcstartE = (c == 2); mcdstE = 5;
            tick();
        end
        mcstartE = 0;
        #1;
        check("mc_c5_busy", 16'(mcbusy), 16'd0);
        check("mc_c5_stallD", 16'(stallD), 16'd0);
        check("mc_c5_done", 16'(mcdone), 16'd0);
        idle_inputs();
        tick();

        // Branch penalty 2: three stall cycles, fetch never stalls
        pcsrcD = 1;
        for (int c = 1; c <= 3; c++) begin
            #1;
            check($sformatf("br_c%0d_stallD", c), 16'(stallD), 16'd1);
            check($sformatf("br_c%0d_stallF", c), 16'(stallF), 16'd0);
            tick();
            pcsrcD = 0;
        end
        check("br_end_stallD", 16'(stallD), 16'd0);

        // Taken branch while counter non-zero does not reload
        pcsrcD = 1;
        tick();
        tick();
        pcsrcD = 0;
        #1;
        check("br_noreload_c2", 16'(stallD), 16'd1);
        tick();
        check("br_noreload_end", 16'(stallD), 16'd0);

        // Multi-cycle op with unrelated registers, mcopD interlock, reset mid-op
        mcstartE = 1; mcdstE = 6; rsD = 1; rdD = 1;
        tick();
        mcstartE = 0;
        check("mcop_busy", 16'(mcbusy), 16'd1);
        check("mcop_nodep_stallD", 16'(stallD), 16'd0);
        mcopD = 1;
        #1;
        check("mcop_stallD", 16'(stallD), 16'd1);
        tick();
        reset = 1;
        tick();
        reset = 0;
        check("rst_mid_busy", 16'(mcbusy), 16'd0);
        check("rst_mid_done", 16'(mcdone), 16'd0);
        check("rst_mid_stallD", 16'(stallD), 16'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("rst_after_c%0d_done", c), 16'(mcdone | mcbusy), 16'd0);
        end
        idle_inputs();

`ifdef HAZARD_PERF_EN
        reset = 1;
        tick();
        reset = 0;
        memtoregE = 1; writeregE = 4; rdD = 4;
        for (int c = 0; c < 10; c++) tick();
        idle_inputs();
        tick();
        check("perf_stalls_10", perf_stalls, 16'd10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
